// File: rtl/cop0_irq_sequencer_pkg.sv
// Shared COP0 definitions: sequencer states, handler vector, register map and
// STATUS/CAUSE field positions used by the pipeline-side interrupt logic.
package cop0_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_TAKE,
    ST_RECOVER,
    ST_ERET_GO
  } seq_state_e;

  localparam logic [31:0] HANDLER_VECTOR_DEFAULT = 32'hC000_0180;

  localparam logic [4:0] COP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] COP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] COP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] COP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] COP0_REG_EPC     = 5'd14;

  localparam int unsigned STATUS_IE_BIT = 0;
  localparam int unsigned IRQ_FIELD_MSB = 15;
  localparam int unsigned IRQ_FIELD_LSB = 10;

  // Same reduction COP0 performs to drive InterruptRequest.
  function automatic logic irq_pending(input logic [31:0] status,
                                       input logic [31:0] cause);
    return status[STATUS_IE_BIT] &
           (|(status[IRQ_FIELD_MSB:IRQ_FIELD_LSB] & cause[IRQ_FIELD_MSB:IRQ_FIELD_LSB]));
  endfunction

endpackage

// File: rtl/cop0_irq_sequencer.sv
// Chooses a safe EX boundary for taking an interrupt, flushes, redirects to the
// handler and pulses InterruptHandled; also sequences ERET back to EPC.
module cop0_irq_sequencer
  import cop0_pkg::*;
#(
  parameter logic [31:0] HANDLER_VECTOR = HANDLER_VECTOR_DEFAULT,
  parameter logic [31:0] DSLOT_ADJ      = 32'd4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        InterruptRequest,
  input  logic        ExValid,
  input  logic [31:0] ExPC,
  input  logic        ExInDelaySlot,
  input  logic        ExIsEret,
  input  logic        Cop0WriteEnable,
  input  logic        MemStall,
  input  logic [31:0] EPC,
  output logic        Flush,
  output logic        Busy,
  output logic        PCRedirect,
  output logic [31:0] RedirectTarget,
  output logic [31:0] InterruptedPC,
  output logic        InterruptHandled,
  output logic        StatusRestore
);

  seq_state_e  state_q, state_d;
  logic [31:0] int_pc_q, int_pc_d;
  logic [31:0] eret_pc_q, eret_pc_d;
  logic        flush_c;
  logic        ready;
  logic        eret_ok;
  logic        pulse_ok;
  logic [31:0] restart_pc;

  // A pending MTC0 must retire first since it may clear IE.
  assign ready      = ExValid & ~MemStall & ~Cop0WriteEnable;
  assign eret_ok    = ExValid & ExIsEret & ~MemStall;
  assign restart_pc = ExInDelaySlot ? (ExPC - DSLOT_ADJ) : ExPC;
  assign pulse_ok   = Enable & ~Reset;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      int_pc_q  <= '0;
      eret_pc_q <= '0;
    end else if (Enable) begin
      state_q   <= state_d;
      int_pc_q  <= int_pc_d;
      eret_pc_q <= eret_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    int_pc_d  = int_pc_q;
    eret_pc_d = eret_pc_q;
    flush_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Interrupt wins over a simultaneous ERET; the ERET becomes the restart point.
        if (InterruptRequest) begin
          if (ready) begin
            flush_c  = 1'b1;
            int_pc_d = restart_pc;
            state_d  = ST_TAKE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (eret_ok) begin
          flush_c   = 1'b1;
          eret_pc_d = EPC;
          state_d   = ST_ERET_GO;
        end
      end
      ST_DRAIN: begin
        if (!InterruptRequest) begin
          state_d = ST_IDLE;
        end else if (ready) begin
          flush_c  = 1'b1;
          int_pc_d = restart_pc;
          state_d  = ST_TAKE;
        end
      end
      ST_TAKE:    state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      ST_ERET_GO: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Flush            = flush_c & pulse_ok;
    Busy             = (state_q != ST_IDLE);
    PCRedirect       = 1'b0;
    RedirectTarget   = '0;
    InterruptHandled = 1'b0;
    StatusRestore    = 1'b0;
    InterruptedPC    = int_pc_q;
    if (pulse_ok) begin
      unique case (state_q)
        ST_TAKE: begin
          PCRedirect       = 1'b1;
          RedirectTarget   = HANDLER_VECTOR;
          InterruptHandled = 1'b1;
        end
        ST_ERET_GO: begin
          PCRedirect     = 1'b1;
          RedirectTarget = eret_pc_q;
          StatusRestore  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cop0_irq_sequencer.md
Name: cop0_irq_sequencer

Overview:
Pipeline-side controller for the COP0 interrupt unit. It watches InterruptRequest and picks a safe instruction boundary in EX. It then flushes the pipeline, supplies the restart PC with delay-slot correction, and pulses InterruptHandled so COP0 latches EPC and clears IE. It also redirects fetch to the handler. It sequences ERET as well: redirects to EPC and requests the IE re-enable.

Parameters:
HANDLER_VECTOR, 32'hC000_0180, interrupt handler entry address
DSLOT_ADJ, 32'd4, subtracted from ExPC when the interrupted instruction sits in a branch delay slot

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high
Enable  in  1  clock enable, shared with COP0
InterruptRequest  in  1  from COP0 (ie & |(im & ip))
ExValid  in  1  EX stage holds a real instruction
ExPC  in  32  PC of the EX instruction
ExInDelaySlot  in  1  EX instruction is in a branch delay slot
ExIsEret  in  1  EX instruction is ERET
Cop0WriteEnable  in  1  MTC0 in EX this cycle
MemStall  in  1  pipeline frozen by memory/UART
EPC  in  32  current COP0 EPC value
Flush  out  1  kill EX and all younger instructions this cycle
Busy  out  1  hold fetch/decode (no new instructions enter)
PCRedirect  out  1  load RedirectTarget into the PC
RedirectTarget  out  32  redirect address
InterruptedPC  out  32  to COP0 InterruptedPC; registered
InterruptHandled  out  1  to COP0; one-cycle pulse
StatusRestore  out  1  one-cycle pulse; COP0 sets status[0]=1

Behaviour:
- States: IDLE, DRAIN, TAKE, RECOVER, ERET_GO. All state and registers update only when Enable=1.
- When Enable=0: state holds, and all pulse outputs (Flush, PCRedirect, InterruptHandled, StatusRestore) are forced to 0.
- ready = ExValid & !MemStall & !Cop0WriteEnable. A pending MTC0 always completes first, because it may clear IE.
- IDLE:
  - IR & ready: Flush=1 combinationally this cycle. InterruptedPC <= ExInDelaySlot ? ExPC-DSLOT_ADJ : ExPC (mod 2^32, so 0 becomes 0xFFFF_FFFC). Next state TAKE.
  - IR & !ready: next state DRAIN.
  - !IR & ExIsEret & ExValid & !MemStall: Flush=1. Target register <= EPC. Next state ERET_GO.
  - IR and ERET in the same cycle: the interrupt wins. The ERET is squashed, its PC becomes InterruptedPC, and no StatusRestore is issued.
- DRAIN:
  - Busy=1.
  - IR & ready: same capture and Flush as IDLE, then TAKE.
  - IR deasserts (IE/IM cleared by software): return to IDLE with no pulse.
  - No timeout.
- TAKE (one cycle): InterruptHandled=1, PCRedirect=1, RedirectTarget=HANDLER_VECTOR, Busy=1. Next state RECOVER.
- RECOVER (one cycle): Busy=1. InterruptRequest is ignored, because COP0 has already cleared IE at the TAKE edge. Next state IDLE.
- ERET_GO (one cycle): PCRedirect=1, RedirectTarget=captured EPC, StatusRestore=1, Busy=1. Next state IDLE.
- Latency: capture cycle C, InterruptHandled at C+1, IDLE again at C+3. ERET redirect at C+1, IDLE at C+2.
- RedirectTarget is 0 when PCRedirect=0.
- Reset at any point: state=IDLE, InterruptedPC=0, captured EPC=0, all outputs 0. An interrupt in progress is abandoned; the COP0 pending bits persist, so it retakes later.
- Outputs are Moore-decoded from state, except Flush in the capture cycle.

Decomposition:
- Package cop0_pkg holds:
  - the state enum;
  - the HANDLER_VECTOR default;
  - COP0 register addresses: COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14;
  - the STATUS IE bit index 0, and the IM/IP field [15:10].
- Single module; no sub-module warranted.

Test Plan:
1. Basic take: IR=1, ExValid=1, ExPC=0x1000_0040, slot=0 -> Flush at C; at C+1 InterruptHandled=1, PCRedirect=1, RedirectTarget=0xC000_0180, InterruptedPC=0x1000_0040; Busy at C+1..C+2; IDLE at C+3.
2. Delay slot: ExPC=0x1000_0044, slot=1 -> InterruptedPC=0x1000_0040. ExPC=0, slot=1 -> 0xFFFF_FFFC.
3. Drain: IR=1, MemStall=1 for 3 cycles -> Busy=1 and no Flush for 3 cycles, take on the 4th cycle. Repeat with IR dropped on cycle 2 -> IDLE, no InterruptHandled. Repeat with Cop0WriteEnable=1 for 1 cycle -> take is delayed by 1 cycle.
4. ERET: EPC=0x1000_0040, ExIsEret=1, IR=0 -> Flush at C; at C+1 PCRedirect=1, RedirectTarget=0x1000_0040, StatusRestore=1 for exactly one cycle.
5. Collision: IR=1 and ExIsEret=1 with ExPC=0x1000_0080 -> interrupt taken, InterruptedPC=0x1000_0080, StatusRestore never asserted.
6. Reset asserted in TAKE, and Enable=0 held in DRAIN -> Reset: all outputs 0 next cycle, state IDLE. Enable=0: state frozen, pulses 0; resumes identically when Enable returns.
